bcd_serial_converter: RTL
=========================

Name: bcd_serial_converter

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock. It sits between the 18-bit accumulator stage and the six seven-segment decoders. It takes the accumulator's bin_18 value and drives one 4-bit digit per display, replacing a wide combinational divide path with a small iterative datapath. It provides a start/busy/done handshake and an optional auto-convert-on-change mode.

Parameters:
BIN_W, 18, width of the binary input; must satisfy 2^BIN_W - 1 < 10^DIGITS.
DIGITS, 6, number of BCD output digits.
AUTO_START, 0, when 1 the block starts a conversion by itself whenever bin_in differs from the last converted value.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  conversion request; sampled only in IDLE.
bin_in  input  BIN_W  unsigned binary value to convert.
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse when new digits are valid.
digit_1 .. digit_6  output  4 each  BCD digits; digit_1 = units, digit_6 = hundred-thousands.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, busy=0, done=0, all digits=0, bit counter=0, scratch registers=0, last-converted register=0. Asserting reset mid-conversion aborts the conversion; digits read 0 afterwards.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Trigger = start, or (AUTO_START=1 and bin_in != last-converted).
  - On trigger at edge k: latch bin_in into the shift register, clear the BCD scratch, set counter=0, go to SHIFT.
  - Otherwise hold.
- SHIFT, one step per edge:
  - Every BCD scratch nibble >= 5 gets +3.
  - Then shift {scratch, binary} left by 1; the binary MSB enters scratch bit 0.
  - counter += 1.
  - After BIN_W steps (edges k+1 .. k+BIN_W), go to DONE.
- DONE, at edge k+BIN_W+1:
  - Copy scratch into the digit_1..digit_6 output registers.
  - Record the converted value into last-converted.
  - done=1 for exactly that one cycle.
  - Return to IDLE.
- Latency: start sampled at edge k; done high and digits valid after edge k+19 (default widths). The next start is accepted at edge k+20 at the earliest.
- busy is registered and high from after edge k until edge k+19 inclusive; it is low again in the cycle after done.
- Handshakes during a conversion:
  - start while busy (SHIFT or DONE) is ignored, not queued.
  - bin_in changes after capture do not affect the running conversion.
  - With AUTO_START, a change during busy is caught by the compare once back in IDLE.
- Output digits hold their previous value throughout a conversion and never show partial results.
- Values: bin_in is unsigned. 0 converts to all-zero digits. The maximum 262143 converts without overflow. Digits are always in 0..9.
- Counter width: clog2(BIN_W+1). Scratch width: 4*DIGITS.

Decomposition:
- Shared package holds:
  - BIN_W and DIGITS defaults.
  - bcd_digit_t (4-bit) type.
  - State enum {IDLE, SHIFT, DONE}.
  - Constant ADD3_THRESHOLD = 5.
- One natural sub-module: bcd_add3, a combinational nibble corrector (in >= 5 ? in+3 : in). It is instantiated DIGITS times via generate inside the SHIFT datapath.
- The FSM and counter stay in the top module.

Test Plan:
- Reset then idle: rst_n=0 → 1, no start for 50 cycles → busy=0, done never pulses, all digits=0.
- Basic conversion and timing: bin_in=262143, start pulse at edge k → busy=1 from edge k; done=1 only after edge k+19; digits 6..1 = 2,6,2,1,4,3; busy=0 after edge k+20.
- Corner values back-to-back: 0 → all zeros, then 1023 → 0,0,1,0,2,3, then 100000 → 1,0,0,0,0,0. Each start is issued the cycle after busy falls; each gives exactly one done pulse.
- Start during busy ignored: start at k with 12345, second start at k+5 with 999 → one done only, digits 0,1,2,3,4,5; no further busy.
- Reset mid-operation: start 54321, assert rst_n=0 at edge k+9 → busy=0 and digits=0 immediately (asynchronously); no done pulse; a fresh start after release gives 0,5,4,3,2,1.
- AUTO_START=1: hold bin_in=42 → exactly one conversion, digits 0,0,0,0,4,2, then idle. Change bin_in to 43 mid-conversion → after the first done, a second conversion starts in IDLE and gives 43.

Source files
------------

// File: rtl/bcd_serial_converter_pkg.sv
// Shared types and constants for the serial binary-to-BCD converter.
package bcd_serial_converter_pkg;

   localparam int unsigned BinWDefault   = 18;
   localparam int unsigned DigitsDefault = 6;

   typedef logic [3:0] bcd_digit_t;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StShift = 2'd1;
   localparam logic [1:0] StDone  = 2'd2;

   localparam bcd_digit_t Add3Threshold = 4'd5;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble corrector: adds 3 to any digit of 5 or more before the shift.
module bcd_add3
   import bcd_serial_converter_pkg::*;
(
   input  bcd_digit_t nibble_i,
   output bcd_digit_t nibble_o
);

   assign nibble_o = (nibble_i >= Add3Threshold) ? nibble_i + 4'd3 : nibble_i;

endmodule

// File: rtl/bcd_serial_converter.sv
// Iterative binary-to-BCD converter, one double-dabble step per clock, with a
// start/busy/done handshake and optional auto-convert when the input changes.
module bcd_serial_converter
   import bcd_serial_converter_pkg::*;
#(
   parameter int unsigned BinW      = BinWDefault,
   parameter int unsigned Digits    = DigitsDefault,
   parameter bit          AutoStart = 1'b0
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic [BinW-1:0] bin_in_i,
   output logic            busy_o,
   output logic            done_o,
   output bcd_digit_t      digit_1_o,
   output bcd_digit_t      digit_2_o,
   output bcd_digit_t      digit_3_o,
   output bcd_digit_t      digit_4_o,
   output bcd_digit_t      digit_5_o,
   output bcd_digit_t      digit_6_o
);

   localparam int unsigned CntW = $clog2(BinW + 1);
   localparam int unsigned ScrW = 4 * Digits;

   logic [1:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [BinW-1:0] bin_q, bin_d;
   logic [BinW-1:0] cap_q, cap_d;
   logic [BinW-1:0] last_q, last_d;
   logic [ScrW-1:0] scr_q, scr_d;
   logic [ScrW-1:0] digits_q, digits_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [ScrW-1:0] adj;
   logic            trigger;

   for (genvar g = 0; g < Digits; g++) begin : g_add3
      bcd_add3 u_add3 (
         .nibble_i (scr_q[4*g +: 4]),
         .nibble_o (adj[4*g +: 4])
      );
   end

   assign trigger = start_i | (AutoStart && (bin_in_i != last_q));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bin_d    = bin_q;
      cap_d    = cap_q;
      last_d   = last_q;
      scr_d    = scr_q;
      digits_d = digits_q;
      done_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (trigger) begin
               bin_d   = bin_in_i;
               cap_d   = bin_in_i;
               scr_d   = '0;
               cnt_d   = '0;
               state_d = StShift;
            end
         end
         StShift: begin
            {scr_d, bin_d} = {adj, bin_q} << 1;
            cnt_d          = cnt_q + CntW'(1);
            if (cnt_q == CntW'(BinW - 1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            // Outputs update only here so partial results never reach the displays.
            digits_d = scr_q;
            last_d   = cap_q;
            done_d   = 1'b1;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
      // Busy stays up through the done cycle.
      busy_d = (state_d != StIdle) | done_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         bin_q    <= '0;
         cap_q    <= '0;
         last_q   <= '0;
         scr_q    <= '0;
         digits_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bin_q    <= bin_d;
         cap_q    <= cap_d;
         last_q   <= last_d;
         scr_q    <= scr_d;
         digits_q <= digits_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign digit_1_o = digits_q[3:0];
   assign digit_2_o = digits_q[7:4];
   assign digit_3_o = digits_q[11:8];
   assign digit_4_o = digits_q[15:12];
   assign digit_5_o = digits_q[19:16];
   assign digit_6_o = digits_q[23:20];

endmodule
